mips32_mem_arbiter: RTL and testbench

Single-clock arbiter sharing one unified single-ported instruction/data memory of the pipelined MIPS32 core among three requesters: instruction fetch (IF stage), data access (MEM stage LW/SW), and an optional program loader. It serializes accesses, inserts configurable memory wait states, and returns a one-cycle acknowledge with read data. A starvation guard keeps fetch progressing under sustained data traffic.

---
 rtl/mips32_mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter
// Shares one single-ported instruction/data memory among instruction fetch
// (if_*), MEM-stage data access (dm_*) and a program loader (ld_*).
// One access is in flight at a time: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
// Every output is a flop. An ack is a one-cycle pulse, and the matching rdata
// register updates in the same cycle.
//
// Ports:
//   clk1, rst_n                    clock, async active-low reset
//   if_req/if_addr                 fetch read request   -> if_ack/if_rdata
//   dm_req/dm_we/dm_addr/dm_wdata  data LW/SW request   -> dm_ack/dm_rdata
//   ld_req/ld_addr/ld_wdata        loader write request -> ld_ack
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata   memory side
//   busy                           high whenever the FSM is not IDLE
//
// Build option: define MIPS32_ARB_LOADER_EN to let the loader arbitrate.
// When it is undefined, the ld_* inputs are ignored and ld_ack stays 0.
module mips32_mem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {P_IF, P_DM, P_LD} port_t;

    localparam logic [3:0] WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t        state_q, state_d;
    port_t         owner_q, owner_d;
    logic          we_q, we_d;
    logic [3:0]    wait_q, wait_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, ld_ack_q, ld_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic          busy_q, busy_d;

    logic          ld_v, starve_hit, gnt_v, gnt_we, take;
    port_t         gnt_port;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;

`ifdef MIPS32_ARB_LOADER_EN
    assign ld_v = ld_req;
`else
    logic unused_ld;
    assign ld_v      = 1'b0;
    assign unused_ld = ^{ld_req, ld_addr, ld_wdata};
`endif

    // Arbitration: ld > dm > if. Once fetch has lost STARVE_LIMIT times in a
    // row, it overrides everything.
    assign starve_hit = if_req && (starve_q == STARVE_MAX);

    always_comb begin
        gnt_v     = 1'b1;
        gnt_port  = P_IF;
        gnt_we    = 1'b0;
        gnt_addr  = if_addr;
        gnt_wdata = '0;
        if (!starve_hit && ld_v) begin
            gnt_port  = P_LD;
            gnt_we    = 1'b1;
            gnt_addr  = ld_addr;
            gnt_wdata = ld_wdata;
        end else if (!starve_hit && dm_req) begin
            gnt_port  = P_DM;
            gnt_we    = dm_we;
            gnt_addr  = dm_addr;
            gnt_wdata = dm_wdata;
        end else if (!if_req) begin
            gnt_v = 1'b0;
        end
    end

    assign take = (state_q == S_IDLE) && gnt_v;

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (gnt_v) state_d = S_ISSUE;
            S_ISSUE: state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (wait_q == 4'd0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath. Every *_d here becomes a registered output.
    always_comb begin
        owner_d     = take ? gnt_port : owner_q;
        we_d        = take ? gnt_we : we_q;
        mem_en_d    = take;
        mem_we_d    = take && gnt_we;
        mem_addr_d  = take ? gnt_addr : mem_addr_q;
        mem_wdata_d = take ? gnt_wdata : mem_wdata_q;

        wait_d = wait_q;
        if (state_q == S_ISSUE)
            wait_d = WS_LOAD;
        else if (state_q == S_WAIT && wait_q != 4'd0)
            wait_d = wait_q - 4'd1;

        // Fetch's losing streak. It only counts IDLE cycles that grant
        // another port while fetch is waiting.
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (!if_req || (gnt_v && gnt_port == P_IF))
                starve_d = 4'd0;
            else if (gnt_v && starve_q != STARVE_MAX)
                starve_d = starve_q + 4'd1;
        end

        if_ack_d   = (state_q == S_RESP) && (owner_q == P_IF);
        dm_ack_d   = (state_q == S_RESP) && (owner_q == P_DM);
        ld_ack_d   = (state_q == S_RESP) && (owner_q == P_LD);
        if_rdata_d = if_ack_d ? mem_rdata : if_rdata_q;
        dm_rdata_d = (dm_ack_d && !we_q) ? mem_rdata : dm_rdata_q;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= P_IF;
            we_q        <= 1'b0;
            wait_q      <= 4'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            ld_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            we_q        <= we_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            ld_ack_q    <= ld_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign ld_ack    = ld_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Bench for mips32_mem_arbiter (WAIT_STATES=2, STARVE_LIMIT=4).
// Part 1 runs table-driven data transactions.
// Part 2 runs hand sequences for contention, starvation, the loader and
// reset in the middle of an access.
// Part 3 drives random traffic and checks it against a transaction-level model.
module tb_mips32_mem_arbiter;
    localparam int AW = 10, DW = 32, WS = 2, LIMIT = 4, SLOT = 3 + WS;
`ifdef MIPS32_ARB_LOADER_EN
    localparam bit LDEN = 1'b1;
`else
    localparam bit LDEN = 1'b0;
`endif

    logic          clk1 = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, ld_req = 1'b0;
    logic [AW-1:0] if_addr = '0, dm_addr = '0, ld_addr = '0;
    logic [DW-1:0] dm_wdata = '0, ld_wdata = '0, mem_rdata;
    logic          if_ack, dm_ack, ld_ack, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mips32_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    // Synchronous single-port memory. Read data appears the cycle after mem_en.
    logic [DW-1:0] mem [1024];
    bit            mem_wr [1024];
    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 120) ? 32'd85 : (32'hA5A5_0000 | 32'(a));
    endfunction
    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]    <= mem_wdata;
                mem_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : init_val(int'(mem_addr));
            end
        end
    end

    int vectors = 0, miscompares = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"}, 32'({if_ack, dm_ack, ld_ack, mem_en, mem_we, busy}), 32'd0);
        chk({nm, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_if_rdata"}, if_rdata, 32'd0);
        chk({nm, "_dm_rdata"}, dm_rdata, 32'd0);
    endtask

    // Runs one data access starting at a negedge. Returns the number of
    // negedges until the ack, the first cycle mem_en was seen, and how many
    // cycles mem_en and mem_we were high.
    task automatic dm_xact(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output int lat, output int en_lat,
                           output int en_cnt, output int we_cnt);
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
        lat = 0; en_lat = 0; en_cnt = 0; we_cnt = 0;
        do begin
            @(negedge clk1);
            lat++;
            if (mem_en && en_lat == 0) en_lat = lat;
            en_cnt += int'(mem_en);
            we_cnt += int'(mem_we);
        end while (!dm_ack && lat < 40);
        dm_req = 1'b0;
        rd = dm_rdata;
    endtask

    // Records ack order (0 = if, 1 = dm, 2 = ld) and the cycle of each ack.
    int ord [8];
    int when_c [8];
    int n_got;
    function automatic void rec(input int code, input int cyc);
        if (n_got < 8) begin ord[n_got] = code; when_c[n_got] = cyc; end
        n_got++;
    endfunction
    task automatic collect(input int n, input bit hold_dm);
        int cyc;
        cyc = 0; n_got = 0;
        for (int i = 0; i < 8; i++) begin ord[i] = -1; when_c[i] = -1; end
        while (n_got < n && cyc < 200) begin
            @(negedge clk1);
            cyc++;
            if (ld_ack) begin rec(2, cyc); ld_req = 1'b0; end
            if (dm_ack) begin rec(1, cyc); if (!hold_dm) dm_req = 1'b0; end
            if (if_ack) begin rec(0, cyc); if_req = 1'b0; end
        end
        chk("collect_count", 32'(n_got), 32'(n));
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(negedge clk1);
            chk("drain_no_ack", 32'({if_ack, dm_ack, ld_ack}), 32'd0);
        end
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    // Random-phase reference state
    bit            pend [3];
    logic [AW-1:0] ra [3];
    logic [DW-1:0] rw [3];
    bit            rwe;
    int            timer, own, starve, win;
    bit            own_rd;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] ref_mem [1024];
    logic [2:0]    eack;

    initial begin
        vec_t          tbl [10];
        logic [DW-1:0] rd;
        int            lat, en_lat, en_cnt, we_cnt;

        tbl[0] = '{1'b0, 10'd120,  32'd0,          32'd85};
        tbl[1] = '{1'b1, 10'd121,  32'd130,        32'd85};
        tbl[2] = '{1'b0, 10'd121,  32'd0,          32'd130};
        tbl[3] = '{1'b1, 10'd122,  32'hDEADBEEF,   32'd130};
        tbl[4] = '{1'b0, 10'd122,  32'd0,          32'hDEADBEEF};
        tbl[5] = '{1'b1, 10'd0,    32'd5,          32'hDEADBEEF};
        tbl[6] = '{1'b0, 10'd0,    32'd0,          32'd5};
        tbl[7] = '{1'b0, 10'd1023, 32'd0,          32'hA5A503FF};
        tbl[8] = '{1'b0, 10'd120,  32'd0,          32'd85};
        tbl[9] = '{1'b1, 10'd1023, 32'd1,          32'd85};

        // Reset state
        repeat (3) @(negedge clk1);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk1);
        check_zero("post_reset");

        // Table: back-to-back data accesses
        foreach (tbl[i]) begin
            dm_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, lat, en_lat, en_cnt, we_cnt);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_latency", i), 32'(lat - 1), 32'(2 + WS));
            chk($sformatf("tbl%0d_en_cycle", i), 32'(en_lat), 32'd1);
            chk($sformatf("tbl%0d_en_count", i), 32'(en_cnt), 32'd1);
            chk($sformatf("tbl%0d_we_count", i), 32'(we_cnt), 32'(tbl[i].we));
        end

        // Fetch and data requested together: data first, fetch one slot later
        if_addr = 10'd0; if_req = 1'b1;
        dm_addr = 10'd120; dm_we = 1'b0; dm_req = 1'b1;
        collect(2, 1'b0);
        chk("sim_first",  32'(ord[0]), 32'd1);
        chk("sim_second", 32'(ord[1]), 32'd0);
        chk("sim_dm_cyc", 32'(when_c[0]), 32'(SLOT));
        chk("sim_if_cyc", 32'(when_c[1]), 32'(2 * SLOT));
        chk("sim_if_rdata", if_rdata, 32'd5);
        chk("sim_dm_rdata", dm_rdata, 32'd85);
        drain(6);

        // Starvation: data held continuously, fetch wins the 5th slot
        if_addr = 10'd1; if_req = 1'b1;
        dm_addr = 10'd120; dm_we = 1'b0; dm_req = 1'b1;
        collect(6, 1'b1);
        dm_req = 1'b0;
        for (int i = 0; i < 6; i++)
            chk($sformatf("starve_grant%0d", i), 32'(ord[i]), (i == 4) ? 32'd0 : 32'd1);
        chk("starve_if_cyc", 32'(when_c[4]), 32'(5 * SLOT));
        chk("starve_if_rdata", if_rdata, 32'hA5A50001);
        drain(6);

        // Loader contending with data and fetch on the same word
        ld_addr = 10'd200; ld_wdata = 32'd77; ld_req = 1'b1;
        dm_addr = 10'd200; dm_we = 1'b0; dm_req = 1'b1;
        if_addr = 10'd200; if_req = 1'b1;
`ifdef MIPS32_ARB_LOADER_EN
        collect(3, 1'b0);
        chk("ld_grant0", 32'(ord[0]), 32'd2);
        chk("ld_grant1", 32'(ord[1]), 32'd1);
        chk("ld_grant2", 32'(ord[2]), 32'd0);
        chk("ld_dm_rdata", dm_rdata, 32'd77);
        chk("ld_if_rdata", if_rdata, 32'd77);
`else
        collect(2, 1'b0);
        chk("ldoff_grant0", 32'(ord[0]), 32'd1);
        chk("ldoff_grant1", 32'(ord[1]), 32'd0);
        chk("ldoff_dm_rdata", dm_rdata, 32'hA5A500C8);
        chk("ldoff_if_rdata", if_rdata, 32'hA5A500C8);
        drain(8);
        ld_req = 1'b0;
`endif
        drain(4);

        // Reset while in WAIT: everything clears, no ack, then full re-service
        dm_addr = 10'd120; dm_we = 1'b0; dm_req = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        chk("rstwait_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero("rstwait");
        @(negedge clk1);
        chk("rstwait_no_ack", 32'(dm_ack), 32'd0);
        rst_n = 1'b1;
        dm_xact(1'b0, 10'd120, 32'd0, rd, lat, en_lat, en_cnt, we_cnt);
        chk("rstwait_rdata", rd, 32'd85);
        chk("rstwait_latency", 32'(lat - 1), 32'(2 + WS));

        // Random traffic against the transaction-level model
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_wr[i] ? mem[i] : init_val(i);
        for (int p = 0; p < 3; p++) begin pend[p] = 1'b0; ra[p] = '0; rw[p] = '0; end
        rwe = 1'b0; timer = 0; own = 0; starve = 0; own_rd = 1'b0; exp_rd = '0;
        repeat (1500) begin
            @(negedge clk1);
            eack = 3'b000;
            if (timer > 0) begin
                timer--;
                if (timer == 0) eack[own] = 1'b1;
            end
            chk("rnd_acks", 32'({ld_ack, dm_ack, if_ack}), 32'(eack));
            if (eack != 3'b000 && own_rd)
                chk((own == 0) ? "rnd_if_rdata" : "rnd_dm_rdata",
                    (own == 0) ? if_rdata : dm_rdata, exp_rd);
            for (int p = 0; p < 3; p++) if (eack[p]) pend[p] = 1'b0;
            // Requesters: raise new requests and sometimes change pending ones.
            // Whatever is on the bus when the arbiter samples is what counts.
            for (int p = 0; p < 3; p++) begin
                if ((!pend[p] && $urandom_range(0, 2) == 0) || (pend[p] && $urandom_range(0, 3) == 0)) begin
                    pend[p] = 1'b1;
                    ra[p] = 10'($urandom_range(0, 15));
                    rw[p] = $urandom;
                    if (p == 1) rwe = 1'($urandom_range(0, 1));
                end
            end
            if (timer == 0) begin
                win = -1;
                if (pend[0] && starve == LIMIT) win = 0;
                else if (LDEN && pend[2])       win = 2;
                else if (pend[1])               win = 1;
                else if (pend[0])               win = 0;
                if (win == 0 || !pend[0])            starve = 0;
                else if (win > 0 && starve < LIMIT)  starve++;
                if (win >= 0) begin
                    own = win;
                    timer = SLOT;
                    own_rd = (win == 0) || (win == 1 && !rwe);
                    if (own_rd) exp_rd = ref_mem[ra[win]];
                    else        ref_mem[ra[win]] = rw[win];
                end
            end
            if_req = pend[0]; if_addr = ra[0];
            dm_req = pend[1]; dm_addr = ra[1]; dm_we = rwe; dm_wdata = rw[1];
            ld_req = pend[2]; ld_addr = ra[2]; ld_wdata = rw[2];
        end
        if_req = 1'b0; dm_req = 1'b0; ld_req = 1'b0;
        repeat (SLOT + 3) @(negedge clk1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
